// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial add/subtract sequencer:
//   FSM state encoding and operation select constants.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// fa_cell
//   Purely combinational 1-bit full adder, the single arithmetic cell
//   time-shared by serial_add_ctrl.
// Ports
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Adds or subtracts two WIDTH-bit operands bit-serially, LSB first, one
//   bit per clock, through a single fa_cell. A request accepted at edge E
//   yields a one-cycle done pulse after edge E+WIDTH+1.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   op     : 0 = a+b+cin, 1 = a-b (cin ignored), sampled with start
//   a, b   : operands, sampled with start
//   cin    : carry in for addition, sampled with start
//   busy   : high while the sequencer is not idle
//   done   : one-cycle pulse, result valid
//   sum    : result, held until the next completed operation
//   cout   : carry out of the MSB (for subtraction 1 = no borrow)
//   ovf    : signed overflow
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             msb_cin;
   logic             fa_s;
   logic             fa_co;

   fa_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_s),
      .cout (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         msb_cin <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is a + ~b + 1: invert b and force carry-in.
                  a_sh  <= a;
                  b_sh  <= (op == OP_SUB) ? ~b : b;
                  carry <= (op == OP_SUB) ? 1'b1 : cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               res_sh <= {fa_s, res_sh[WIDTH-1:1]};
               carry  <= fa_co;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               if (cnt == LAST) begin
                  // carry currently holds the carry into the MSB
                  msb_cin <= carry;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               sum   <= res_sh;
               cout  <= carry;
               ovf   <= msb_cin ^ carry;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed bench: a WIDTH=8 instance driven from a vector table plus
//   hand-written start-while-busy and mid-run reset sequences, and a WIDTH=2
//   instance checked exhaustively against an arithmetic model.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8, op8, cin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   logic       start2, op2, cin2;
   logic [1:0] a2, b2;
   logic       busy2, done2, cout2, ovf2;
   logic [1:0] sum2;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
      .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   typedef struct {
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] es;
      logic       ec;
      logic       eo;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Packed view {done, busy, cout, ovf, sum}
   function automatic logic [31:0] obs8();
      return {20'd0, done8, busy8, cout8, ovf8, sum8};
   endfunction

   function automatic logic [31:0] obs2();
      return {26'd0, done2, busy2, cout2, ovf2, sum2};
   endfunction

   task automatic run8(input vec_t v, input string nm);
      logic [7:0] held;
      bit bad;
      held  = sum8;
      op8   = v.op;
      a8    = v.a;
      b8    = v.b;
      cin8  = v.cin;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      // operands are free to change after the accepting edge
      a8 = ~v.a; b8 = ~v.b; op8 = ~v.op; cin8 = ~v.cin;
      bad = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (k <= 8 && (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== held)) bad = 1'b1;
      end
      chk({nm, "_run"}, {31'd0, bad}, 32'd0);
      chk({nm, "_res"}, obs8(), {20'd0, 1'b1, 1'b0, v.ec, v.eo, v.es});
   endtask

   task automatic run2(input logic o, input logic [1:0] x, input logic [1:0] y, input logic c);
      logic [1:0] bb;
      logic       ci;
      logic [2:0] full;
      logic       eo;
      bit         bad;
      bb   = o ? ~y : y;
      ci   = o ? 1'b1 : c;
      full = {1'b0, x} + {1'b0, bb} + {2'b00, ci};
      eo   = (x[1] == bb[1]) && (full[1] != x[1]);
      op2 = o; a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      bad = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (k <= 2 && (busy2 !== 1'b1 || done2 !== 1'b0)) bad = 1'b1;
      end
      chk($sformatf("w2_op%0d_a%0d_b%0d_c%0d", o, x, y, c), obs2() | {31'd0, bad} << 8,
          {26'd0, 1'b1, 1'b0, full[2], eo, full[1:0]});
      a2 = ~x; b2 = ~y;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("w2_hold_op%0d_a%0d_b%0d_c%0d", o, x, y, c), obs2(),
          {26'd0, 1'b0, 1'b0, full[2], eo, full[1:0]});
   endtask

   initial begin
      vec_t v;
      int   dcnt;
      bit   bad;

      tv[0] = '{1'b0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
      tv[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tv[2] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      tv[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
      tv[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      tv[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      tv[6] = '{1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0};
      tv[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tv[8] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};

      rst_n = 1'b0;
      start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset8", obs8(), 32'd0);
      chk("reset2", obs2(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors, issued back to back (start in the done cycle)
      for (int i = 0; i < 9; i++) run8(tv[i], $sformatf("vec%0d", i));

      // start re-pulsed mid-run: ignored, a single done pulse
      op8 = 1'b0; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      dcnt = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (k == 3) begin
            start8 = 1'b1; op8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
         end
         if (k == 4) start8 = 1'b0;
         if (done8 === 1'b1) dcnt++;
      end
      chk("busy_start_res", obs8(), {20'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h96});
      chk("busy_start_pulses", dcnt, 32'd1);
      v = '{1'b0, 8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0};
      run8(v, "after_done");

      // Reset asserted while bit 4 is being processed
      op8 = 1'b0; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_pre_busy", {31'd0, busy8}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", obs8(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
      end
      chk("abort_no_done", {31'd0, bad}, 32'd0);
      run8(tv[3], "post_abort");

      // WIDTH=2 exhaustive
      for (int o = 0; o < 2; o++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
               for (int c = 0; c < 2; c++)
                  run2(o[0], x[1:0], y[1:0], c[0]);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
